// File: rtl/calc_pkg.sv
// Shared definitions for the hex keypad calculator: key codes, FSM states
// and a small key-classification helper.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_EQ  = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd5;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle for WIDTH cycles.
// done_o and product_o are valid together during the final busy cycle.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;

  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Expose the post-step accumulator so the final product is usable on the same edge busy drops.
  assign product_o = acc_d;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH);
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Hex keypad calculator: operand entry, add/sub/mul modulo 2^WIDTH.
// state   | meaning
// ENTER_A | entering first operand
// ENTER_B | operator chosen, entering second operand
// CALC    | producing result (1 cycle add/sub, WIDTH cycles mul)
// SHOW    | result on display
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = WIDTH / 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             num_pressed,
  input  logic             op_pressed,
  input  logic [3:0]       operator,
  input  logic [3:0]       hex,
  output logic [WIDTH-1:0] display,
  output logic             busy,
  output logic             result_valid,
  output logic             overflow
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e             state_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   display_q;
  logic [3:0]         op_q;
  logic [CW-1:0]      count_q;
  logic               result_valid_q;
  logic               overflow_q;

  logic               clr_d;
  logic               mul_start_d;
  logic [WIDTH-1:0]   entry_d;
  logic [WIDTH:0]     sum_d;
  logic [WIDTH:0]     diff_d;
  logic [WIDTH-1:0]   res_d;
  logic               res_ovf_d;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  always_comb begin
    clr_d       = op_pressed && (operator == OP_CLR);
    mul_start_d = op_pressed && (operator == OP_EQ) && (state_q == ENTER_B) && (op_q == OP_MUL);
    entry_d     = {operand_q[WIDTH-5:0], hex};
    sum_d       = {1'b0, a_q} + {1'b0, operand_q};
    diff_d      = {1'b0, a_q} - {1'b0, operand_q};
    if (op_q == OP_SUB) begin
      res_d     = diff_d[WIDTH-1:0];
      res_ovf_d = diff_d[WIDTH];
    end else if (op_q == OP_MUL) begin
      res_d     = mul_product[WIDTH-1:0];
      res_ovf_d = |mul_product[2*WIDTH-1:WIDTH];
    end else begin
      res_d     = sum_d[WIDTH-1:0];
      res_ovf_d = sum_d[WIDTH];
    end
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clock),
    .rst_i     (reset),
    .clr_i     (clr_d),
    .start_i   (mul_start_d),
    .a_i       (a_q),
    .b_i       (operand_q),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clock) begin
    if (reset || clr_d) begin
      state_q        <= ENTER_A;
      operand_q      <= '0;
      a_q            <= '0;
      display_q      <= '0;
      op_q           <= '0;
      count_q        <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        CALC: begin
          if ((op_q != OP_MUL) || mul_done) begin
            display_q      <= res_d;
            overflow_q     <= res_ovf_d;
            result_valid_q <= 1'b1;
            state_q        <= SHOW;
          end
        end
        default: begin
          // An operator strobe wins over a simultaneous digit strobe.
          if (op_pressed) begin
            if (is_arith(operator)) begin
              op_q <= operator;
              if (state_q != ENTER_B) begin
                a_q       <= (state_q == SHOW) ? display_q : operand_q;
                operand_q <= '0;
                count_q   <= '0;
                state_q   <= ENTER_B;
              end
            end else if ((operator == OP_EQ) && (state_q == ENTER_B)) begin
              state_q <= CALC;
            end
          end else if (num_pressed) begin
            if (state_q == SHOW) begin
              operand_q  <= {{(WIDTH-4){1'b0}}, hex};
              display_q  <= {{(WIDTH-4){1'b0}}, hex};
              count_q    <= CW'(1);
              overflow_q <= 1'b0;
              state_q    <= ENTER_A;
            end else if (count_q < CW'(MAX_DIGITS)) begin
              operand_q  <= entry_d;
              display_q  <= entry_d;
              count_q    <= count_q + CW'(1);
              overflow_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign display      = display_q;
  assign busy         = mul_busy;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: calculator-level reference model feeding a result
// scoreboard, plus per-cycle display/overflow/busy checks.
module tb_calc_engine;

  localparam int W = 16;
  localparam int MAXD = 4;
  localparam longint unsigned MOD = 64'd65536;
  localparam logic [3:0] K_ADD = 4'd1;
  localparam logic [3:0] K_SUB = 4'd2;
  localparam logic [3:0] K_MUL = 4'd3;
  localparam logic [3:0] K_EQ  = 4'd4;
  localparam logic [3:0] K_CLR = 4'd5;

  logic         clock = 1'b0;
  logic         reset;
  logic         num_pressed;
  logic         op_pressed;
  logic [3:0]   operator;
  logic [3:0]   hex;
  logic [W-1:0] display;
  logic         busy;
  logic         result_valid;
  logic         overflow;

  calc_engine #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .clock        (clock),
    .reset        (reset),
    .num_pressed  (num_pressed),
    .op_pressed   (op_pressed),
    .operator     (operator),
    .hex          (hex),
    .display      (display),
    .busy         (busy),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [W-1:0] disp;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;
  exp_t sb[$];

  // Calculator model state
  longint unsigned m_cur = 0, m_acc = 0;
  int              m_ndig = 0;
  logic [3:0]      m_pend = 4'd0;
  bit              m_have_op = 0, m_shown = 0, m_mul = 0;
  logic [W-1:0]    m_disp = '0;
  logic            m_ovf = 1'b0;
  int unsigned     done_edge = 0, m_mstart = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Cancel every result whose completion edge is at or after edge e.
  function automatic void flush_from(input int unsigned e);
    exp_t keep[$];
    foreach (sb[i]) if (sb[i].cyc < e) keep.push_back(sb[i]);
    sb = keep;
  endfunction

  task automatic model_clear(input int unsigned j);
    flush_from(j + 1);
    m_cur = 0; m_acc = 0; m_ndig = 0; m_pend = 4'd0;
    m_have_op = 0; m_shown = 0; m_mul = 0;
    m_disp = '0; m_ovf = 1'b0; done_edge = 0; m_mstart = 0;
  endtask

  task automatic model_key(input bit np, input bit opp, input logic [3:0] code, input logic [3:0] h);
    int unsigned j = cyc;
    bit computing = (j < done_edge);
    longint unsigned a, b, full, res;
    bit ovf;
    exp_t e;
    if (opp) begin
      if (code == K_CLR) model_clear(j);
      else if (computing) ;
      else if (code == K_ADD || code == K_SUB || code == K_MUL) begin
        if (m_shown) begin
          m_acc = m_disp; m_cur = 0; m_ndig = 0; m_have_op = 1; m_shown = 0;
        end else if (!m_have_op) begin
          m_acc = m_cur; m_cur = 0; m_ndig = 0; m_have_op = 1;
        end
        m_pend = code;
      end else if (code == K_EQ && m_have_op) begin
        a = m_acc; b = m_cur;
        if (m_pend == K_ADD) begin
          full = a + b; ovf = (full >= MOD); res = full % MOD;
        end else if (m_pend == K_SUB) begin
          ovf = (a < b); res = (a + MOD - b) % MOD;
        end else begin
          full = a * b; ovf = (full >= MOD); res = full % MOD;
        end
        m_mul = (m_pend == K_MUL);
        m_mstart = j + 1;
        done_edge = m_mul ? (j + 1 + W) : (j + 2);
        e.disp = W'(res); e.ovf = ovf; e.cyc = done_edge;
        sb.push_back(e);
        m_disp = W'(res); m_ovf = ovf; m_shown = 1; m_have_op = 0;
      end
    end else if (np && !computing) begin
      if (m_shown) begin
        m_cur = h; m_ndig = 1; m_disp = W'(h); m_ovf = 1'b0; m_shown = 0;
      end else if (m_ndig < MAXD) begin
        m_cur = m_cur * 16 + h; m_ndig++; m_disp = W'(m_cur); m_ovf = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_busy = m_mul && (cyc >= m_mstart) && (cyc < done_edge);
    chk("busy", 32'(busy), 32'(exp_busy));
    if (cyc >= done_edge) begin
      chk("display", 32'(display), 32'(m_disp));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  endtask

  task automatic step(input bit np, input bit opp, input logic [3:0] code, input logic [3:0] h, input bit rst);
    @(negedge clock);
    check_outputs();
    if (rst) model_clear(cyc);
    else model_key(np, opp, code, h);
    reset = rst;
    num_pressed = np && !rst;
    op_pressed = opp && !rst;
    operator = code;
    hex = h;
  endtask

  task automatic digit(input logic [3:0] h); step(1'b1, 1'b0, 4'd0, h, 1'b0); endtask
  task automatic key(input logic [3:0] c);   step(1'b0, 1'b1, c, 4'd0, 1'b0); endtask
  task automatic rst_pulse();                step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t ent;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++; failed++;
      $display("FAIL missing_result: got no result_valid, expected one at cycle %0d (now %0d)", sb[0].cyc, cyc);
      ent = sb.pop_front();
    end
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; failed++;
        $display("FAIL spurious_result_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        ent = sb.pop_front();
        chk("result_display", 32'(display), 32'(ent.disp));
        chk("result_overflow", 32'(overflow), 32'(ent.ovf));
        chk("result_cycle", cyc, ent.cyc);
      end
    end
  end

  int unsigned r_sel;
  logic [3:0]  r_hex;

  initial begin
    reset = 1'b1; num_pressed = 1'b0; op_pressed = 1'b0; operator = 4'd0; hex = 4'd0;
    repeat (3) @(negedge clock);

    // First key lands on the edge right after reset drops.
    digit(4'h1); digit(4'h2); idle(1);
    chk("digits_12", 32'(display), 32'h0012);
    chk("digits_12_rv", 32'(result_valid), 32'h0);
    chk("digits_12_busy", 32'(busy), 32'h0);

    key(K_CLR); digit(4'h1); digit(4'h2); key(K_ADD); digit(4'h3); digit(4'h4); key(K_EQ);
    idle(1);
    chk("add_not_early", 32'(result_valid), 32'h0);
    idle(1);
    chk("add_12_34", 32'(display), 32'h0046);
    chk("add_rv_pulse", 32'(result_valid), 32'h1);
    chk("add_ovf", 32'(overflow), 32'h0);
    idle(1);
    chk("add_rv_one_cycle", 32'(result_valid), 32'h0);

    key(K_CLR); digit(4'hF); digit(4'hF); digit(4'hF); digit(4'hF); key(K_ADD); digit(4'h1); key(K_EQ);
    idle(2);
    chk("add_carry_val", 32'(display), 32'h0000);
    chk("add_carry_ovf", 32'(overflow), 32'h1);
    key(K_SUB); digit(4'h1); key(K_EQ);
    idle(2);
    chk("sub_borrow_val", 32'(display), 32'hFFFF);
    chk("sub_borrow_ovf", 32'(overflow), 32'h1);

    key(K_CLR); digit(4'h1); digit(4'h2); key(K_MUL); digit(4'h3); key(K_EQ);
    idle(W);
    chk("mul_busy_last", 32'(busy), 32'h1);
    idle(1);
    chk("mul_12_3", 32'(display), 32'h0036);
    chk("mul_busy_drop", 32'(busy), 32'h0);
    key(K_CLR); digit(4'h1); digit(4'h0); digit(4'h0); key(K_MUL);
    digit(4'h1); digit(4'h0); digit(4'h0); key(K_EQ);
    idle(W + 1);
    chk("mul_ovf_val", 32'(display), 32'h0000);
    chk("mul_ovf_flag", 32'(overflow), 32'h1);

    key(K_CLR); digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4); digit(4'h5); idle(1);
    chk("fifth_digit_ignored", 32'(display), 32'h1234);
    key(K_CLR); digit(4'h5); step(1'b1, 1'b1, K_ADD, 4'h9, 1'b0); digit(4'h1); key(K_EQ);
    idle(2);
    chk("digit_op_same_cycle", 32'(display), 32'h0006);

    key(K_CLR); digit(4'h1); digit(4'h2); key(K_MUL); digit(4'h3); key(K_EQ);
    idle(4); key(K_CLR); idle(1);
    chk("clr_mid_mul_disp", 32'(display), 32'h0);
    chk("clr_mid_mul_busy", 32'(busy), 32'h0);
    chk("clr_mid_mul_rv", 32'(result_valid), 32'h0);
    idle(W + 2);
    digit(4'h7); key(K_ADD); digit(4'h1); key(K_EQ); idle(2);
    chk("after_clr_7p1", 32'(display), 32'h0008);

    key(K_CLR); digit(4'h1); digit(4'h2); key(K_MUL); digit(4'h3); key(K_EQ);
    idle(4); rst_pulse(); idle(1);
    chk("rst_mid_mul_disp", 32'(display), 32'h0);
    chk("rst_mid_mul_busy", 32'(busy), 32'h0);
    chk("rst_mid_mul_rv", 32'(result_valid), 32'h0);
    idle(W + 2);
    digit(4'h7); key(K_ADD); digit(4'h1); key(K_EQ); idle(2);
    chk("after_rst_7p1", 32'(display), 32'h0008);

    for (int i = 0; i < 1500; i++) begin
      r_sel = $urandom_range(0, 99);
      r_hex = 4'($urandom_range(0, 15));
      if (r_sel < 45) digit(r_hex);
      else if (r_sel < 63) key(4'($urandom_range(1, 3)));
      else if (r_sel < 76) key(K_EQ);
      else if (r_sel < 78) key(K_CLR);
      else if (r_sel < 83) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), r_hex, 1'b0);
      else if (r_sel < 87) key(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(6, 15)));
      else if (r_sel < 88) rst_pulse();
      else idle(1);
    end

    idle(W + 4);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
